i2c_cmd_seq: RTL

I2C_CMD_SEQ -- requirements
Module: i2c_cmd_seq

---
 rtl/i2c_pkg.sv | 40 ++++
 rtl/n_counter.sv | 28 ++
 rtl/i2c_cmd_seq.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// I2C command sequencer shared types:
// FSM states, response codes, request bundle.
package i2c_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_BUSY,
    S_XFER,
    S_BACKOFF,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_ADDR = 2'd1,
    ERR_DATA = 2'd2,
    ERR_TMO  = 2'd3
  } rsp_err_t;

  typedef struct packed {
    logic       rd;
    logic [7:0] idx;
    logic [7:0] wdata;
  } req_t;

  function automatic rsp_err_t resolve_err(
    input logic tmo,
    input logic na,
    input logic nd
  );
    if (tmo) return ERR_TMO;
    if (na)  return ERR_ADDR;
    if (nd)  return ERR_DATA;
    return ERR_OK;
  endfunction

endpackage

// File: rtl/n_counter.sv
// Loadable down-counter with a zero flag.
// Saturates at zero while enabled.
module n_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/i2c_cmd_seq.sv
// Register read/write sequencer in front of an
// I2C byte master, with address-NACK retry.
module i2c_cmd_seq
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR      = 7'h1D,
  parameter int         RETRY_MAX     = 2,
  parameter int         BACKOFF_CYC   = 1000,
  parameter int         BUSY_WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_read,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic       m_start,
  output logic [6:0] m_addr7,
  output logic [7:0] m_wr_len,
  output logic [7:0] m_rd_len,
  input  logic       m_busy,
  input  logic       m_done,
  input  logic       m_nack_addr,
  input  logic       m_nack_data,
  input  logic       m_timeout,
  output logic [7:0] m_wr_data,
  output logic       m_wr_valid,
  input  logic       m_wr_ready,
  input  logic [7:0] m_rd_data,
  input  logic       m_rd_valid,
  output logic       m_rd_ready
);

  localparam logic [CNT_W-1:0] BW_LD =
    CNT_W'(BUSY_WAIT_MAX - 1);
  localparam logic [CNT_W-1:0] BO_LD =
    CNT_W'(BACKOFF_CYC - 1);
  localparam logic [7:0] RT_MAX = 8'(RETRY_MAX);

  state_t     state;
  req_t       req_q;
  logic       rdy_en_q;
  logic [1:0] idx_q;
  logic [7:0] retry_q;
  logic [7:0] rd_q;
  logic       na_q, nd_q, to_q;

  logic       na_all, nd_all, to_all;
  rsp_err_t   err_res;
  rsp_err_t   err_nx;
  logic       retry_go;
  logic       go_resp;
  logic [7:0] rd_nx;

  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_zero;
  logic [CNT_W-1:0] tmr_val;

  assign req_ready  = rdy_en_q && (state == S_IDLE);
  assign m_rd_ready = (state == S_XFER);
  assign m_wr_valid = (state == S_XFER) &&
                      ({6'd0, idx_q} < m_wr_len);
  assign m_wr_data  = idx_q[0] ? req_q.wdata
                               : req_q.idx;

  // Flags seen in the m_done cycle count too.
  assign na_all   = na_q | m_nack_addr;
  assign nd_all   = nd_q | m_nack_data;
  assign to_all   = to_q | m_timeout;
  assign err_res  = resolve_err(to_all, na_all, nd_all);
  assign retry_go = (err_res == ERR_ADDR) &&
                    (retry_q < RT_MAX);
  assign rd_nx    = m_rd_valid ? m_rd_data : rd_q;

  assign tmr_load = (state == S_LAUNCH) ||
                    (state == S_XFER && m_done && retry_go);
  assign tmr_val  = (state == S_LAUNCH) ? BW_LD : BO_LD;
  assign tmr_en   = (state == S_WAIT_BUSY) ||
                    (state == S_BACKOFF);

  always_comb begin
    go_resp = 1'b0;
    err_nx  = ERR_OK;
    if (state == S_WAIT_BUSY && !m_busy && tmr_zero) begin
      go_resp = 1'b1;
      err_nx  = ERR_TMO;
    end else if (state == S_XFER && m_done && !retry_go) begin
      go_resp = 1'b1;
      err_nx  = err_res;
    end
  end

  n_counter #(.W(CNT_W)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      req_q     <= '0;
      rdy_en_q  <= 1'b0;
      idx_q     <= '0;
      retry_q   <= '0;
      rd_q      <= '0;
      na_q      <= 1'b0;
      nd_q      <= 1'b0;
      to_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= '0;
      m_start   <= 1'b0;
      m_addr7   <= '0;
      m_wr_len  <= '0;
      m_rd_len  <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      m_start  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            req_q    <= '{req_read, req_reg, req_wdata};
            retry_q  <= '0;
            rsp_err  <= ERR_OK;
            rd_q     <= '0;
            idx_q    <= '0;
            na_q     <= 1'b0;
            nd_q     <= 1'b0;
            to_q     <= 1'b0;
            m_addr7  <= DEV_ADDR;
            m_wr_len <= req_read ? 8'd1 : 8'd2;
            m_rd_len <= req_read ? 8'd1 : 8'd0;
            m_start  <= 1'b1;
            state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_WAIT_BUSY;
        S_WAIT_BUSY: begin
          if (m_busy) state <= S_XFER;
        end
        S_XFER: begin
          if (m_wr_valid && m_wr_ready) idx_q <= idx_q + 2'd1;
          rd_q <= rd_nx;
          na_q <= na_all;
          nd_q <= nd_all;
          to_q <= to_all;
          if (m_done && retry_go) begin
            retry_q <= retry_q + 8'd1;
            state   <= S_BACKOFF;
          end
        end
        S_BACKOFF: begin
          if (tmr_zero) begin
            na_q    <= 1'b0;
            nd_q    <= 1'b0;
            to_q    <= 1'b0;
            idx_q   <= '0;
            m_start <= 1'b1;
            state   <= S_LAUNCH;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
      if (go_resp) begin
        state     <= S_RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= err_nx;
        rsp_rdata <= (req_q.rd && err_nx == ERR_OK)
                     ? rd_nx : 8'h00;
        m_addr7   <= '0;
        m_wr_len  <= '0;
        m_rd_len  <= '0;
      end
    end
  end

endmodule
